// File: rtl/exu_csr_seq.sv
// Sequential CSR execution unit: handshake in, variable-latency CSR read,
// conditional write-back to the CSR file, old value returned over a second handshake.
module exu_csr_seq #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           inst_i,
    input  logic [XLEN-1:0]       rs1_data_i,
    input  logic                  int_assert_i,
    output logic                  csr_re_o,
    output logic [CSR_ADDR_W-1:0] csr_raddr_o,
    input  logic                  csr_rvalid_i,
    input  logic [XLEN-1:0]       csr_rdata_i,
    output logic                  csr_we_o,
    output logic [CSR_ADDR_W-1:0] csr_waddr_o,
    output logic [XLEN-1:0]       csr_wdata_o,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [4:0]            wb_rd_o,
    output logic                  wb_we_o,
    output logic [XLEN-1:0]       wb_data_o,
    output logic                  illegal_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WB} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             inst_q;
    logic [XLEN-1:0]         opnd_q;
    logic [XLEN-1:0]         rdata_q;
    logic                    illegal_q;

    // RW forms always write; set/clear forms only when the source field is non-zero.
    function automatic logic write_req(input logic [2:0] f3, input logic [4:0] src);
        return (f3[1:0] == 2'b01) || (f3[1] && (src != 5'd0));
    endfunction

    function automatic logic [XLEN-1:0] new_value(input logic [2:0] f3,
                                                  input logic [XLEN-1:0] old,
                                                  input logic [XLEN-1:0] opnd);
        case (f3[1:0])
            2'b01:   return opnd;
            2'b10:   return old | opnd;
            2'b11:   return old & ~opnd;
            default: return '0;
        endcase
    endfunction

    logic [2:0]            in_f3;
    logic [4:0]            in_src;
    logic                  in_illegal;
    logic [XLEN-1:0]       in_opnd;
    logic                  accept;

    assign in_f3      = inst_i[14:12];
    assign in_src     = inst_i[19:15];
    assign in_illegal = (inst_i[6:0] != 7'b1110011) || (in_f3[1:0] == 2'b00) ||
                        (write_req(in_f3, in_src) && (inst_i[31:30] == 2'b11));
    assign in_opnd    = in_f3[2] ? {{(XLEN-5){1'b0}}, in_src} : rs1_data_i;
    assign accept     = (state_q == IDLE) && in_valid_i && !int_assert_i;

    logic [2:0]            q_f3;
    logic [4:0]            q_src;
    logic [4:0]            q_rd;
    logic [CSR_ADDR_W-1:0] q_addr;
    logic                  q_wreq;

    assign q_f3   = inst_q[14:12];
    assign q_src  = inst_q[19:15];
    assign q_rd   = inst_q[11:7];
    assign q_addr = inst_q[20 +: CSR_ADDR_W];
    assign q_wreq = write_req(q_f3, q_src);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            inst_q    <= '0;
            opnd_q    <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                inst_q    <= inst_i;
                opnd_q    <= in_opnd;
                illegal_q <= in_illegal;
            end
            if ((state_q == READ) && !int_assert_i && csr_rvalid_i) begin
                rdata_q <= csr_rdata_i;
            end
        end
    end

    // Outputs are decoded from the state alone, so an async reset clears them at once.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        busy_o      = 1'b1;
        csr_re_o    = 1'b0;
        csr_raddr_o = '0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        wb_valid_o  = 1'b0;
        wb_rd_o     = '0;
        wb_we_o     = 1'b0;
        wb_data_o   = '0;
        illegal_o   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                busy_o     = 1'b0;
                if (accept) begin
                    state_d = in_illegal ? WB : READ;
                end
            end
            READ: begin
                csr_re_o    = 1'b1;
                csr_raddr_o = q_addr;
                if (int_assert_i) begin
                    state_d = IDLE;
                end else if (csr_rvalid_i) begin
                    state_d = q_wreq ? WRITE : WB;
                end
            end
            WRITE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = q_addr;
                csr_wdata_o = new_value(q_f3, rdata_q, opnd_q);
                state_d     = WB;
            end
            WB: begin
                wb_valid_o = 1'b1;
                wb_rd_o    = q_rd;
                wb_we_o    = (q_rd != 5'd0) && !illegal_q;
                wb_data_o  = illegal_q ? '0 : rdata_q;
                illegal_o  = illegal_q;
                if (wb_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exu_csr_seq.sv
// Bench for exu_csr_seq: directed vector table, randomized transactions against a
// rule-level reference model, and hand-written interrupt / back-pressure / reset sequences.
module tb_exu_csr_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic        int_assert_i = 1'b0;
    logic        csr_re_o;
    logic [11:0] csr_raddr_o;
    logic        csr_rvalid_i = 1'b0;
    logic [31:0] csr_rdata_i = '0;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        illegal_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exu_csr_seq #(.XLEN(32), .CSR_ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .rs1_data_i(rs1_data_i), .int_assert_i(int_assert_i),
        .csr_re_o(csr_re_o), .csr_raddr_o(csr_raddr_o),
        .csr_rvalid_i(csr_rvalid_i), .csr_rdata_i(csr_rdata_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
        .illegal_o(illegal_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] old;
        int          delay;
        int          stall;
        logic        e_ill;
        logic        e_wr;
        logic [31:0] e_wdata;
        logic [31:0] e_wb;
        logic [4:0]  e_rd;
        logic        e_wbwe;
        int          e_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [11:0] addr, input logic [4:0] src,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
        return {addr, src, f3, rd, op};
    endfunction

    // Reference model: what the instruction should do, from the ISA rules.
    function automatic vec_t model(input logic [31:0] inst, input logic [31:0] rs1,
                                   input logic [31:0] old, input int delay, input int stall);
        vec_t        v;
        int          kind;   // 0 none, 1 RW, 2 set, 3 clear
        int unsigned opnd;
        int unsigned src;
        int unsigned addr;
        src  = inst[19:15];
        addr = inst[31:20];
        case (inst[14:12])
            3'b001, 3'b101: kind = 1;
            3'b010, 3'b110: kind = 2;
            3'b011, 3'b111: kind = 3;
            default:        kind = 0;
        endcase
        opnd      = inst[14] ? src : rs1;
        v.inst    = inst;
        v.rs1     = rs1;
        v.old     = old;
        v.delay   = delay;
        v.stall   = stall;
        v.e_wr    = (kind == 1) || (kind != 0 && src != 0);
        v.e_ill   = (inst[6:0] != 7'h73) || (kind == 0) || (v.e_wr && addr >= 12'hC00);
        if (v.e_ill) v.e_wr = 1'b0;
        v.e_wdata = (kind == 1) ? opnd : (kind == 2) ? (old | opnd) : (old & ~opnd);
        v.e_wb    = v.e_ill ? 32'd0 : old;
        v.e_rd    = inst[11:7];
        v.e_wbwe  = (inst[11:7] != 0) && !v.e_ill;
        v.e_lat   = v.e_ill ? 1 : 2 + delay + (v.e_wr ? 1 : 0);
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int k, re_cnt, we_cnt, lat, stall_left;
        bit done;
        @(negedge clk);
        chk("ready_idle", {31'd0, in_ready_o}, 32'd1);
        in_valid_i = 1'b1;
        inst_i     = v.inst;
        rs1_data_i = v.rs1;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        inst_i     = '0;
        rs1_data_i = '0;
        k = 0; re_cnt = 0; we_cnt = 0; lat = -1; stall_left = v.stall; done = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            csr_rvalid_i = 1'b0;
            csr_rdata_i  = '0;
            if (csr_re_o) begin
                re_cnt++;
                chk("raddr", {20'd0, csr_raddr_o}, {20'd0, v.inst[31:20]});
                if (re_cnt > v.delay) begin
                    csr_rvalid_i = 1'b1;
                    csr_rdata_i  = v.old;
                end
            end
            if (csr_we_o) begin
                we_cnt++;
                chk("re_we_excl", {31'd0, csr_re_o}, 32'd0);
                chk("waddr", {20'd0, csr_waddr_o}, {20'd0, v.inst[31:20]});
                chk("wdata", csr_wdata_o, v.e_wdata);
            end
            if (wb_valid_o) begin
                if (lat < 0) begin
                    lat = k;
                    chk("latency", lat, v.e_lat);
                end
                chk("wb_data", wb_data_o, v.e_wb);
                chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, v.e_rd});
                chk("wb_we", {31'd0, wb_we_o}, {31'd0, v.e_wbwe});
                chk("illegal", {31'd0, illegal_o}, {31'd0, v.e_ill});
                chk("ready_in_wb", {31'd0, in_ready_o}, 32'd0);
                if (stall_left > 0) begin
                    wb_ready_i = 1'b0;
                    stall_left--;
                end else begin
                    wb_ready_i = 1'b1;
                    @(posedge clk);
                    #1;
                    wb_ready_i = 1'b0;
                    done = 1;
                end
            end
        end
        chk("no_timeout", {31'd0, done}, 32'd1);
        chk("re_cycles", re_cnt, v.e_ill ? 0 : v.delay + 1);
        chk("we_cycles", we_cnt, v.e_wr ? 1 : 0);
    endtask

    initial begin
        vec_t v;
        int   we_seen, wb_seen;

        vecs[0] = '{mk(12'h300, 5'd1, 3'b001, 5'd5, 7'h73), 32'hDEADBEEF, 32'h1800, 0, 5,
                    1'b0, 1'b1, 32'hDEADBEEF, 32'h1800, 5'd5, 1'b1, 3};
        vecs[1] = '{mk(12'hC00, 5'd0, 3'b010, 5'd3, 7'h73), 32'h0, 32'h12345678, 0, 0,
                    1'b0, 1'b0, 32'h0, 32'h12345678, 5'd3, 1'b1, 2};
        vecs[2] = '{mk(12'hC00, 5'd1, 3'b110, 5'd3, 7'h73), 32'h0, 32'h0, 0, 0,
                    1'b1, 1'b0, 32'h0, 32'h0, 5'd3, 1'b0, 1};
        vecs[3] = '{mk(12'h344, 5'd5, 3'b111, 5'd0, 7'h73), 32'h0, 32'hFF, 3, 1,
                    1'b0, 1'b1, 32'hFA, 32'hFF, 5'd0, 1'b0, 6};
        vecs[4] = '{mk(12'h300, 5'd1, 3'b001, 5'd4, 7'h33), 32'h1, 32'h7, 0, 0,
                    1'b1, 1'b0, 32'h0, 32'h0, 5'd4, 1'b0, 1};
        vecs[5] = '{mk(12'h300, 5'd1, 3'b000, 5'd4, 7'h73), 32'h1, 32'h7, 0, 0,
                    1'b1, 1'b0, 32'h0, 32'h0, 5'd4, 1'b0, 1};
        vecs[6] = '{mk(12'hC01, 5'd0, 3'b001, 5'd9, 7'h73), 32'h11, 32'h0, 0, 0,
                    1'b1, 1'b0, 32'h0, 32'h0, 5'd9, 1'b0, 1};
        vecs[7] = '{mk(12'h305, 5'd2, 3'b011, 5'd7, 7'h73), 32'h0F0F, 32'hFFFF, 1, 2,
                    1'b0, 1'b1, 32'hF0F0, 32'hFFFF, 5'd7, 1'b1, 4};
        vecs[8] = '{mk(12'h340, 5'd31, 3'b101, 5'd1, 7'h73), 32'hAAAAAAAA, 32'h55, 2, 0,
                    1'b0, 1'b1, 32'h1F, 32'h55, 5'd1, 1'b1, 5};

        // Reset state
        #12;
        chk("rst_ready", {31'd0, in_ready_o}, 32'd1);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_re", {31'd0, csr_re_o}, 32'd0);
        chk("rst_we", {31'd0, csr_we_o}, 32'd0);
        chk("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_wbdata", wb_data_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i]);

        for (int i = 0; i < 40; i++) begin
            logic [6:0]  op;
            logic [11:0] addr;
            logic [4:0]  src;
            op   = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'h73;
            addr = 12'($urandom);
            if ($urandom_range(0, 3) == 0) addr[11:10] = 2'b11;
            src  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v = model(mk(addr, src, 3'($urandom), 5'($urandom), op), $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 2));
            run_txn(v);
        end

        // Interrupt while waiting for read data
        @(negedge clk);
        in_valid_i = 1'b1;
        inst_i     = mk(12'h300, 5'd1, 3'b001, 5'd5, 7'h73);
        rs1_data_i = 32'h1234;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        chk("int_in_read", {31'd0, csr_re_o}, 32'd1);
        int_assert_i = 1'b1;
        @(negedge clk);
        int_assert_i = 1'b0;
        chk("int_ready", {31'd0, in_ready_o}, 32'd1);
        chk("int_busy", {31'd0, busy_o}, 32'd0);
        we_seen = 0; wb_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (csr_we_o) we_seen++;
            if (wb_valid_o) wb_seen++;
        end
        chk("int_no_we", we_seen, 0);
        chk("int_no_wb", wb_seen, 0);

        // Request during an interrupt is refused
        in_valid_i   = 1'b1;
        int_assert_i = 1'b1;
        @(negedge clk);
        chk("int_refuse", {31'd0, busy_o}, 32'd0);
        in_valid_i   = 1'b0;
        int_assert_i = 1'b0;

        // Asynchronous reset in WRITE
        @(negedge clk);
        in_valid_i = 1'b1;
        inst_i     = mk(12'h300, 5'd1, 3'b001, 5'd5, 7'h73);
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
        @(negedge clk);
        csr_rvalid_i = 1'b1;
        csr_rdata_i  = 32'h77;
        @(negedge clk);
        csr_rvalid_i = 1'b0;
        chk("pre_rst_we", {31'd0, csr_we_o}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_we", {31'd0, csr_we_o}, 32'd0);
        chk("arst_wbv", {31'd0, wb_valid_o}, 32'd0);
        chk("arst_busy", {31'd0, busy_o}, 32'd0);
        chk("arst_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        run_txn(vecs[7]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
